// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and helpers for the sequential matrix multiplier.
// Holds the controller state encoding, the accumulator width rule, the
// flat-bus slot addressing helper and the unsigned saturation helper.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int DW_DEF   = 16;
  localparam int N_DEF    = 4;
  localparam int ACCW_DEF = 2 * DW_DEF + $clog2(N_DEF);

  // Accumulator width: a full product plus headroom for N additions.
  function automatic int acc_w(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  // Bit offset of element slot idx in a row-major flat bus; slot 0 sits in the MSBs.
  function automatic int slot_off(input int idx, input int n, input int dw);
    return (n * n - 1 - idx) * dw;
  endfunction

  // Unsigned clamp of v to the largest dw-bit value (dw < 64).
  function automatic logic [63:0] sat_u(input logic [63:0] v, input int dw);
    logic [63:0] mx;
    mx = (64'd1 << dw) - 64'd1;
    if (v > mx) begin
      return mx;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/matrix_mac_unit.sv
// matrix_mac_unit: shared multiply-accumulate for matrix_mult_seq.
// Holds the running dot-product sum; on the last term it presents the
// completed element (acc + current product) and clears itself.
// Build option: define SATURATE_EN to clamp stored elements instead of wrapping.
module matrix_mac_unit
  import matrix_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int N    = N_DEF,
  parameter int ACCW = acc_w(DW, N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          last_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] elem_o
);

  logic [2*DW-1:0] prod_s;
  logic [ACCW-1:0] sum_s;
  logic [ACCW-1:0] acc_d;
  logic [ACCW-1:0] acc_q;

  assign prod_s = a_i * b_i;
  assign sum_s  = acc_q + ACCW'(prod_s);

  // Next accumulator value: clear on start, restart after each finished element.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      if (last_i) begin
        acc_d = '0;
      end else begin
        acc_d = sum_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Element value presented to the result file: wrapped or clamped sum.
  always_comb begin
`ifdef SATURATE_EN
    elem_o = DW'(sat_u(64'(sum_s), DW));
`else
    elem_o = sum_s[DW-1:0];
`endif
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: sequential R1xC1 * R2xC2 matrix multiplier (up to NxN).
// One product per RUN cycle through a shared MAC; operands and dimensions
// are captured on an accepted start so the loader may move on at once.
// Build option: SATURATE_EN (see matrix_mac_unit) selects clamping over wrap.
module matrix_mult_seq
  import matrix_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int N  = N_DEF,
  localparam int DIMW = $clog2(N + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N*N*DW-1:0]   flat_matrix_1,
  input  logic [N*N*DW-1:0]   flat_matrix_2,
  input  logic [DIMW-1:0]     R1,
  input  logic [DIMW-1:0]     C1,
  input  logic [DIMW-1:0]     R2,
  input  logic [DIMW-1:0]     C2,
  input  logic                readybit,
  output logic [N*N*DW-1:0]   res_mat,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [DIMW-1:0] ONE  = DIMW'(1);
  localparam logic [DIMW-1:0] DMAX = DIMW'(N);

  state_e              state_q;
  logic [N*N*DW-1:0]   a_q;
  logic [N*N*DW-1:0]   b_q;
  logic [N*N*DW-1:0]   res_q;
  logic [DIMW-1:0]     r1_q;
  logic [DIMW-1:0]     c1_q;
  logic [DIMW-1:0]     c2_q;
  logic [DIMW-1:0]     i_q;
  logic [DIMW-1:0]     j_q;
  logic [DIMW-1:0]     k_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic                start_s;
  logic                dim_ok_s;
  logic                last_s;
  logic                run_s;
  logic [DW-1:0]       a_el_s;
  logic [DW-1:0]       b_el_s;
  logic [DW-1:0]       elem_s;

  // Dimension check and per-cycle control decode.
  always_comb begin
    dim_ok_s = 1'b1;
    if ((R1 == '0) || (C1 == '0) || (R2 == '0) || (C2 == '0)) begin
      dim_ok_s = 1'b0;
    end else if ((R1 > DMAX) || (C1 > DMAX) || (R2 > DMAX) || (C2 > DMAX)) begin
      dim_ok_s = 1'b0;
    end else if (C1 != R2) begin
      dim_ok_s = 1'b0;
    end else begin
      dim_ok_s = 1'b1;
    end
    start_s = (state_q == IDLE) && readybit;
    run_s   = (state_q == RUN);
    last_s  = (k_q == (c1_q - ONE));
  end

  // Operand selection: A[i][k] and B[k][j] from the captured flat buses.
  always_comb begin
    a_el_s = a_q[slot_off(int'(i_q) * N + int'(k_q), N, DW) +: DW];
    b_el_s = b_q[slot_off(int'(k_q) * N + int'(j_q), N, DW) +: DW];
  end

  matrix_mac_unit #(
    .DW (DW),
    .N  (N)
  ) u_mac (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (start_s),
    .en_i   (run_s),
    .last_i (last_s),
    .a_i    (a_el_s),
    .b_i    (b_el_s),
    .elem_o (elem_s)
  );

  // Controller: state, index walk, operand capture and result file.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      r1_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (readybit) begin
            a_q   <= flat_matrix_1;
            b_q   <= flat_matrix_2;
            r1_q  <= R1;
            c1_q  <= C1;
            c2_q  <= C2;
            res_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            if (dim_ok_s) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_s) begin
            res_q[slot_off(int'(i_q) * N + int'(j_q), N, DW) +: DW] <= elem_s;
            k_q <= '0;
            if (j_q == (c2_q - ONE)) begin
              j_q <= '0;
              if (i_q == (r1_q - ONE)) begin
                i_q     <= '0;
                state_q <= FIN;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                i_q <= i_q + ONE;
              end
            end else begin
              j_q <= j_q + ONE;
            end
          end else begin
            k_q <= k_q + ONE;
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign res_mat = res_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: doc/matrix_mult_seq.md
# matrix_mult_seq

Parametrised sequential matrix multiplier: multiplies an R1×C1 matrix by an R2×C2 matrix, each up to N×N elements of DW bits, using one shared multiply-accumulate unit. It is the next generation of the team's fixed 2×2 combinational multiplier and sits behind the operand loader, with a start/done handshake instead of a level-sensitive ready bit. Operands and dimensions are captured on start, so the loader may change its outputs immediately afterwards.

## Interface
- DW, 16, element width in bits, unsigned
- N, 4, maximum matrix dimension; flat buses hold N×N elements
- DIMW, $clog2(N+1), dimension field width (localparam)
- CLK  input  1  clock; all logic on rising edge
- RST  input  1  reset, synchronous, active-high
- flat_matrix_1  input  N*N*DW  operand A, row-major, element (0,0) in the MSBs, element (i,k) at slot i*N+k
- flat_matrix_2  input  N*N*DW  operand B, same layout
- R1, C1, R2, C2  input  DIMW each  operand dimensions
- readybit  input  1  start strobe, sampled only in IDLE
- res_mat  output  N*N*DW  result, same layout; slots outside R1×C2 read 0
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse on completion or error
- err  output  1  valid with done; dimension error

## Operation
- States: IDLE, RUN, FIN.
- IDLE with readybit=1:
  - Capture both operands and all dimensions.
  - Clear res_mat, the accumulator and the indices i, j, k.
  - Valid dimensions go to RUN. Invalid dimensions go to FIN with err set; res_mat stays 0.
- Dimensions are invalid if any is 0, any exceeds N, or C1≠R2.
- RUN, every cycle:
  - acc ← acc + A[i][k]·B[k][j].
  - When k=C1−1, write element (i,j) from acc plus the current product, clear acc, set k←0 and advance j, then i (row-major).
  - Otherwise k←k+1.
  - After element (R1−1,C2−1) is written, go to FIN.
- FIN lasts one cycle: done=1, err valid. Next state is IDLE.
- Arithmetic:
  - Accumulator is 2·DW+$clog2(N) bits, so it never overflows internally.
  - Stored element is the low DW bits (wrap), matching the previous generation's behaviour.
- readybit is ignored in RUN and FIN. It is not queued.
- res_mat holds its value until the next accepted start.
- RST in any state, including mid-RUN: next state IDLE; res_mat, busy, done, err, acc and indices go to 0. Partial results are discarded.

## Timing
- Reset values: res_mat=0, busy=0, done=0, err=0.
- Start accepted at edge t means RUN spans cycles t+1 … t+R1·C2·C1, and done is high in cycle t+1+R1·C2·C1.
- Error case: done=err=1 in cycle t+1.
- res_mat is final and stable in the done cycle.
- busy is high exactly in the RUN cycles.
- readybit high in the FIN cycle is ignored. A new start is accepted in the first IDLE cycle after FIN.

## Configuration
- SATURATE_EN:
  - Defined: each stored element is min(acc, 2^DW−1) (unsigned saturation).
  - Undefined: low DW bits are stored (wrap).
- Latency and handshake are identical in both builds.

## Structure
- Package matrix_pkg holds:
  - the state enum (IDLE, RUN, FIN);
  - ACCW = 2·DW+$clog2(N);
  - a slot-offset function, index i*N+j to bit offset (N*N−1−idx)*DW;
  - the saturate helper.
- Sub-module matrix_mac_unit: registered accumulator with clear and load-result controls, and DW-bit output with wrap or saturate under SATURATE_EN.
- Top level holds the FSM, index counters, operand capture registers and the result register file.

## Test plan
- 2×2 A=[1 2;3 4], B=[5 6;7 8], start at t → res elements [19 22;43 50], remaining slots 0, done in cycle t+9, busy high for 8 cycles.
- Non-square 3×2 · 2×4 (N=4), A=[1 2;3 4;5 6], B all ones → rows [3 3 3 3],[7 7 7 7],[11 11 11 11], row 3 zero, done at t+25.
- C1=2, R2=3 → done=err=1 in cycle t+1, res_mat=0, busy never high.
- 1×1, A=0xFFFF, B=0x0002 → 0xFFFE without SATURATE_EN, 0xFFFF with it.
- Start a 4×4 job, assert RST in cycle t+10 → next cycle all outputs 0 and state IDLE. A following 2×2 job completes correctly.
- readybit held high throughout a 2×2 job → only one done pulse per accepted start. A second start is accepted only after FIN, and operand changes after the accepted start do not affect the result.
